fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencer for the fetch stage. Generates the PC-register enable (`trigger`) and front-end flush/bubble controls from hazard, redirect and debug requests. Owns the boot / run / halt / single-step state machine for the fetch path. Sits between the hazard unit, execute-stage branch resolution and the debug port on one side, and the `fetch` block (`trigger`, `PCSrc` qualification) on the other.

Parameters:
BOOT_CYCLES, 4, cycles after reset release before the first PC advance (range 1..255).
PIPE_DEPTH, 4, stages after fetch that must drain before HALTED is reported (range 1..15).
CNT_WIDTH, 32, width of the fetch counter (used only under the optional feature).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-low; state is reset on a clk edge while rst=0.
stall_req  in  1  hazard unit requests a fetch/decode freeze.
redirect  in  1  execute stage resolved a taken branch/jump (PCSrc=1 this cycle).
halt_req  in  1  debug halt request, level.
resume_req  in  1  debug resume, sampled only in HALTED.
step_req  in  1  debug single-step, sampled only in HALTED.
trigger  out  1  PC register enable to `fetch`.
pc_src_q  out  1  qualified PCSrc to `fetch`: redirect AND trigger.
flush_fd  out  1  insert bubble into the fetch/decode register.
flush_de  out  1  insert bubble into the decode/execute register.
halted  out  1  core front-end is quiescent in HALTED.
state_o  out  3  current state encoding, for debug visibility.

Behaviour:
- States: BOOT=0, RUN=1, DRAIN=2, HALTED=3, STEP=4. All transitions occur on the clk edge.
- Reset (rst=0): state=BOOT; boot_cnt=0; drain_cnt=0; step_pend=0.
- Reset values: trigger=0, pc_src_q=0, flush_fd=1, flush_de=1, halted=0. These are held during reset regardless of the other inputs.
- Reset asserted in any state, mid-drain or mid-step, forces BOOT on the next edge. Pending step and counts are discarded.
- Outputs are combinational from state and inputs. `trigger` must affect the PC in the same cycle as `redirect`.
- BOOT:
  - trigger=0, flush_fd=1, flush_de=1.
  - boot_cnt increments each cycle.
  - When boot_cnt==BOOT_CYCLES-1, go to RUN (halt_req is not checked here).
- RUN:
  - trigger = redirect OR NOT stall_req.
  - flush_fd = redirect; flush_de = redirect OR stall_req.
  - Redirect has priority over stall: the PC takes the target and both front-end registers flush.
  - If halt_req=1 and redirect=0: go to DRAIN with drain_cnt=0. trigger=0 in the transition cycle.
  - If halt_req and redirect are both 1: honour the redirect this cycle, and enter DRAIN on the following edge.
- DRAIN:
  - trigger=0 and flush_fd=1, except that a redirect (an older in-flight branch) still drives trigger=1, flush_fd=1 and flush_de=1.
  - Each redirect cycle restarts drain_cnt at 0. Otherwise drain_cnt increments.
  - At drain_cnt==PIPE_DEPTH-1 with no redirect: go to HALTED.
- HALTED:
  - trigger=0, flush_fd=1, flush_de=1, halted=1.
  - resume_req=1 goes to RUN.
  - Otherwise step_req=1 goes to STEP.
  - resume_req wins if both are set.
- STEP:
  - trigger = NOT stall_req OR redirect.
  - On the first cycle with trigger=1, go to DRAIN (exactly one PC advance).
  - While stalled, remain in STEP with trigger=0.
- pc_src_q=1 only when redirect=1 and trigger=1. A redirect seen in BOOT or HALTED is ignored: pc_src_q=0.
- halted deasserts in the same cycle the state leaves HALTED.

Optional Feature:
FETCH_CTRL_PERF_EN
- Defined:
  - Adds output fetch_cnt [CNT_WIDTH-1:0], which increments on every cycle with trigger=1 and redirect=0.
  - Adds output redirect_cnt [CNT_WIDTH-1:0], which increments on every cycle with pc_src_q=1.
  - Both reset to 0, wrap modulo 2^CNT_WIDTH and never saturate.
- Undefined: neither port nor counter exists, and there is no change to any other behaviour.

Decomposition:
- Shared package fetch_ctrl_pkg holds:
  - the state enum typedef (3-bit) with the encodings above;
  - the constant for the state_o width.
- One natural sub-module, fetch_ctrl_cnt: a parameterised up-counter with synchronous clear and terminal-count compare. It is instantiated for boot_cnt and drain_cnt (and for the perf counters when enabled).
- The FSM stays in fetch_ctrl.

Test Plan:
1. Reset and boot, BOOT_CYCLES=4: hold rst=0 for 3 cycles, then release. Expect trigger=0 and flush_fd=flush_de=1 for exactly 4 cycles after release. Then state_o=1 and trigger=1.
2. RUN, stall vs redirect: stall_req=1 alone gives trigger=0, flush_de=1, flush_fd=0. Then stall_req=1 with redirect=1 in the same cycle gives trigger=1, pc_src_q=1, flush_fd=flush_de=1.
3. Halt with a late redirect, PIPE_DEPTH=4: pulse halt_req in RUN and inject redirect in the 2nd DRAIN cycle. Expect trigger=1 in that cycle only, and drain to restart. halted=1 exactly 4 cycles after the redirect.
4. Single-step: in HALTED, pulse step_req with stall_req=1 for 2 cycles, then 0. Expect exactly one trigger=1 cycle, after the stall clears. Then DRAIN, then halted=1 again after PIPE_DEPTH cycles.
5. Resume and step together: in HALTED assert resume_req=1 and step_req=1. Expect state_o=1 next cycle and halted=0.
6. Reset mid-drain and perf counters (FETCH_CTRL_PERF_EN defined):
   - Run 10 fetches including 2 redirects. Expect fetch_cnt=8 and redirect_cnt=2.
   - Assert rst=0 during DRAIN. Expect BOOT and both counters reading 0 next cycle.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer.
//   state_t : fetch-path FSM state encoding, also exported on state_o
//   STATE_W : width of the state encoding / state_o port
package fetch_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    BOOT   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    HALTED = 3'd3,
    STEP   = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_ctrl_cnt.sv
// Up-counter with synchronous clear and terminal-count compare.
//   clk     : clock, rising edge
//   rst     : synchronous reset, active-low, clears the count
//   clr     : restart the count at zero this edge
//   en      : count this cycle (applied on top of clr, so clr&en loads 1)
//   count   : current count, wraps modulo 2^WIDTH
//   at_term : count equals TERM
module fetch_ctrl_cnt #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TERM  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || en) begin
      count <= (clr ? '0 : count) + WIDTH'(en);
    end
  end

  assign at_term = (count == TERM);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC-register enable (trigger), the
// qualified PCSrc and the front-end flush controls from hazard, redirect
// and debug requests, and owns the boot / run / drain / halted / step FSM.
//
// Ports:
//   clk, rst     : clock (rising edge), synchronous active-low reset
//   stall_req    : hazard unit freeze request
//   redirect     : execute stage resolved a taken branch/jump this cycle
//   halt_req     : debug halt request (level)
//   resume_req   : debug resume, honoured only in HALTED
//   step_req     : debug single step, honoured only in HALTED
//   trigger      : PC register enable
//   pc_src_q     : redirect qualified by trigger
//   flush_fd     : bubble into the fetch/decode register
//   flush_de     : bubble into the decode/execute register
//   halted       : front end quiescent in HALTED
//   state_o      : current FSM state
//   fetch_cnt    : (FETCH_CTRL_PERF_EN only) sequential PC advances
//   redirect_cnt : (FETCH_CTRL_PERF_EN only) taken redirects
//
// Optional feature macro: FETCH_CTRL_PERF_EN adds the two wrap-around
// performance counters; without it the block has no counters at all.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int PIPE_DEPTH  = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_req,
  input  logic               redirect,
  input  logic               halt_req,
  input  logic               resume_req,
  input  logic               step_req,
  output logic               trigger,
  output logic               pc_src_q,
  output logic               flush_fd,
  output logic               flush_de,
  output logic               halted,
  output logic [STATE_W-1:0] state_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] fetch_cnt,
  output logic [CNT_WIDTH-1:0] redirect_cnt
`endif
);

  state_t     state;
  state_t     next_state;
  logic       boot_en;
  logic       boot_term;
  logic       drain_clr;
  logic       drain_en;
  logic       drain_term;
  logic [7:0] boot_cnt_unused;
  logic [3:0] drain_cnt_unused;

  fetch_ctrl_cnt #(
    .WIDTH (8),
    .TERM  (8'(BOOT_CYCLES - 1))
  ) u_boot_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (1'b0),
    .en      (boot_en),
    .count   (boot_cnt_unused),
    .at_term (boot_term)
  );

  // A redirect in DRAIN asserts clr and en together, so the redirect cycle
  // itself counts as drain slot 0 and HALTED follows PIPE_DEPTH cycles later.
  fetch_ctrl_cnt #(
    .WIDTH (4),
    .TERM  (4'(PIPE_DEPTH - 1))
  ) u_drain_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (drain_clr),
    .en      (drain_en),
    .count   (drain_cnt_unused),
    .at_term (drain_term)
  );

  // Outputs are combinational so trigger gates the PC in the same cycle as
  // redirect; while rst is low they are pinned to their reset values.
  always_comb begin
    next_state = state;
    trigger    = 1'b0;
    flush_fd   = 1'b1;
    flush_de   = 1'b1;
    halted     = 1'b0;
    boot_en    = 1'b0;
    drain_clr  = 1'b0;
    drain_en   = 1'b0;
    if (rst) begin
      case (state)
        BOOT: begin
          boot_en = 1'b1;
          if (boot_term) next_state = RUN;
        end
        RUN: begin
          trigger  = redirect | ~stall_req;
          flush_fd = redirect;
          flush_de = redirect | stall_req;
          if (halt_req) begin
            // A simultaneous redirect still takes the target this cycle.
            next_state = DRAIN;
            drain_clr  = 1'b1;
            if (!redirect) trigger = 1'b0;
          end
        end
        DRAIN: begin
          // Only an older in-flight branch may still move the PC here.
          trigger   = redirect;
          flush_de  = redirect | stall_req;
          drain_en  = 1'b1;
          drain_clr = redirect;
          if (!redirect && drain_term) next_state = HALTED;
        end
        HALTED: begin
          halted = 1'b1;
          if (resume_req)    next_state = RUN;
          else if (step_req) next_state = STEP;
        end
        STEP: begin
          trigger  = redirect | ~stall_req;
          flush_fd = redirect;
          flush_de = redirect | stall_req;
          if (trigger) begin
            next_state = DRAIN;
            drain_clr  = 1'b1;
          end
        end
        default: next_state = BOOT;
      endcase
    end
  end

  assign pc_src_q = redirect & trigger;
  assign state_o  = state;

  always_ff @(posedge clk) begin
    if (!rst) state <= BOOT;
    else      state <= next_state;
  end

`ifdef FETCH_CTRL_PERF_EN
  logic fetch_term_unused;
  logic redirect_term_unused;

  fetch_ctrl_cnt #(
    .WIDTH (CNT_WIDTH),
    .TERM  ('0)
  ) u_fetch_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (1'b0),
    .en      (trigger & ~redirect),
    .count   (fetch_cnt),
    .at_term (fetch_term_unused)
  );

  fetch_ctrl_cnt #(
    .WIDTH (CNT_WIDTH),
    .TERM  ('0)
  ) u_redirect_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (1'b0),
    .en      (pc_src_q),
    .count   (redirect_cnt),
    .at_term (redirect_term_unused)
  );
`else
  localparam int cnt_width_unused = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall_req, redirect, halt_req, resume_req, step_req;
  logic       trigger, pc_src_q, flush_fd, flush_de, halted;
  logic [2:0] state_o;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_cnt, redirect_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .BOOT_CYCLES (4),
    .PIPE_DEPTH  (4),
    .CNT_WIDTH   (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .redirect     (redirect),
    .halt_req     (halt_req),
    .resume_req   (resume_req),
    .step_req     (step_req),
    .trigger      (trigger),
    .pc_src_q     (pc_src_q),
    .flush_fd     (flush_fd),
    .flush_de     (flush_de),
    .halted       (halted),
    .state_o      (state_o)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt)
`endif
  );

  typedef struct {
    logic       rst, stall, redir, halt, resume, step;
    logic       trig, pcq, ffd, fde, hlt;
    logic [2:0] st;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic s, logic d, logic h, logic rs, logic sp,
                              logic t, logic q, logic f1, logic f2, logic hl, logic [2:0] st);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = d; v.halt = h; v.resume = rs; v.step = sp;
    v.trig = t; v.pcq = q; v.ffd = f1; v.fde = f2; v.hlt = hl; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_fetch;
    int exp_redir;
    rst = 1'b0; stall_req = 1'b0; redirect = 1'b0;
    halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
    tick();

    //            rst s d h rs sp | trg pcq ffd fde hlt st
    // reset held against active inputs
    vq.push_back(mk(0, 1, 1, 1, 0, 0,  0, 0, 1, 1, 0, 3'd0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0,  0, 0, 1, 1, 0, 3'd0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 3'd0));
    // four boot cycles; redirect and halt ignored
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 3'd0));
    vq.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 3'd0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 3'd0));
    vq.push_back(mk(1, 0, 0, 1, 0, 0,  0, 0, 1, 1, 0, 3'd0));
    // RUN: free run, stall, stall+redirect, redirect
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd1));
    vq.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 3'd1));
    vq.push_back(mk(1, 1, 1, 0, 0, 0,  1, 1, 1, 1, 0, 3'd1));
    vq.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 1, 1, 0, 3'd1));
    // halt pulse, late redirect in 2nd drain cycle restarts the drain
    vq.push_back(mk(1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3'd1));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'd2));
    vq.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 1, 1, 0, 3'd2));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'd2));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'd2));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'd2));
    vq.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0, 1, 1, 1, 3'd3));
    // single step held off by stall, then one advance and a full drain
    vq.push_back(mk(1, 1, 0, 0, 0, 1,  0, 0, 1, 1, 1, 3'd3));
    vq.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 3'd4));
    vq.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 3'd4));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd4));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'd2));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'd2));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'd2));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3'd2));
    // resume and step together: resume wins
    vq.push_back(mk(1, 0, 0, 0, 1, 1,  0, 0, 1, 1, 1, 3'd3));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd1));

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; stall_req = vq[i].stall; redirect = vq[i].redir;
      halt_req = vq[i].halt; resume_req = vq[i].resume; step_req = vq[i].step;
      @(negedge clk);
      chk($sformatf("vec%0d {trg,pcq,ffd,fde,hlt,st}", i),
          32'({trigger, pc_src_q, flush_fd, flush_de, halted, state_o}),
          32'({vq[i].trig, vq[i].pcq, vq[i].ffd, vq[i].fde, vq[i].hlt, vq[i].st}));
      @(posedge clk);
      #1;
    end
    rst = 1'b1; stall_req = 1'b0; redirect = 1'b0;
    halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;

    // Fresh reset, boot again, then ten fetches with two redirects.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("reboot_state%0d", i), 32'(state_o), 32'd0);
      tick();
    end
    exp_fetch = 0;
    exp_redir = 0;
    for (int i = 0; i < 10; i++) begin
      redirect = (i == 3 || i == 7);
      if (redirect) exp_redir++;
      else exp_fetch++;
      @(negedge clk);
      chk($sformatf("run_trigger%0d", i), 32'(trigger), 32'd1);
      tick();
    end
    redirect = 1'b0;
`ifdef FETCH_CTRL_PERF_EN
    @(negedge clk);
    chk("fetch_cnt", fetch_cnt, 32'(exp_fetch));
    chk("redirect_cnt", redirect_cnt, 32'(exp_redir));
`endif

    // Halt, then reset in the middle of the drain.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    @(negedge clk);
    chk("drain_entered", 32'(state_o), 32'd2);
    rst = 1'b0;
    redirect = 1'b1;
    #1;
    chk("rst_in_drain_outputs", 32'({trigger, pc_src_q, flush_fd, flush_de, halted}),
        32'(5'b00110));
    tick();
    chk("rst_in_drain_state", 32'(state_o), 32'd0);
`ifdef FETCH_CTRL_PERF_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_redirect_cnt", redirect_cnt, 32'd0);
`endif
    rst = 1'b1;
    redirect = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
